// File: rtl/joystick_serializer_if.sv
// ---------------------------------------------------------------------------
// joystick_serializer_if
//
// Two-wire joystick shift-register link between a host-side poller and the
// responder that emulates the 16-bit PISO chain.
//
//   joyCk  poller -> responder   serial clock (data advances on its fall)
//   joyLd  poller -> responder   active-low parallel load
//   joyS   poller -> responder   chain select, active-high
//   joyD   responder -> poller   serial data, active-low buttons
//
// master : poller side
// slave  : responder side
// ---------------------------------------------------------------------------
interface joystick_serializer_if;
    logic joyCk;
    logic joyLd;
    logic joyS;
    logic joyD;

    modport master (
        output joyCk,
        output joyLd,
        output joyS,
        input  joyD
    );

    modport slave (
        input  joyCk,
        input  joyLd,
        input  joyS,
        output joyD
    );
endinterface

// File: rtl/joystick_serializer.sv
// ---------------------------------------------------------------------------
// joystick_serializer
//
// Responder end of the two-wire joystick link. Emulates a 16-bit
// parallel-in/serial-out chain so a remote poller clocking joyCk/joyLd
// reconstructs the two joystick states presented on joy1/joy2.
//
// Ports
//   clock      system clock, all logic on its rising edge
//   reset      synchronous, active-high
//   link       slave side of the serial link (joyCk, joyLd, joyS in; joyD out)
//   joy1       joystick 1: bit0 right, 1 left, 2 down, 3 up, 4 fire1,
//              5 fire2; 1 = pressed; bits 7:6 ignored
//   joy2       joystick 2, same layout
//   frameDone  one-clock pulse when the 16th shift after a load happens
//
// Parameter
//   SYNC       synchronizer depth on joyCk/joyLd/joyS, 2..3
//
// Pin edge to joyD update is SYNC+1 clocks: SYNC flops to synchronize, then
// joyD is registered from the next-state shift register in the same clock
// that sr loads or shifts.
// ---------------------------------------------------------------------------
module joystick_serializer #(
    parameter int SYNC = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    joystick_serializer_if.slave        link,
    input  logic [7:0]                  joy1,
    input  logic [7:0]                  joy2,
    output logic                        frameDone
);

    localparam logic [4:0] CNT_FULL = 5'd16;

    // Serial frame word, bit n = t-bit n (t0 shifted out first). Buttons are
    // sent inverted; t0/t1 and t8/t9 are marker bits held high.
    function automatic logic [15:0] load_word(input logic [7:0] j1,
                                              input logic [7:0] j2);
        load_word = {~j1[3], ~j1[2], ~j1[1], ~j1[0], ~j1[4], ~j1[5], 2'b11,
                     ~j2[3], ~j2[2], ~j2[1], ~j2[0], ~j2[4], ~j2[5], 2'b11};
    endfunction

    logic [SYNC-1:0] r_ck_sync;
    logic [SYNC-1:0] r_ld_sync;
    logic [SYNC-1:0] r_s_sync;
    logic            r_ck_hist;
    logic [15:0]     r_sr;
    logic [4:0]      r_cnt;
    logic            r_joyD;
    logic            r_frameDone;

    logic            w_ck;
    logic            w_ld_n;
    logic            w_sel;
    logic            w_load;
    logic            w_shift;
    logic [15:0]     w_sr_next;
    logic [4:0]      w_cnt_next;
    logic            w_done;
    logic            w_unused;

    assign w_unused = ^{joy1[7:6], joy2[7:6]};

    assign w_ck   = r_ck_sync[SYNC-1];
    assign w_ld_n = r_ld_sync[SYNC-1];
    assign w_sel  = r_s_sync[SYNC-1];

    // Load is level-sensitive and overrides any clock edge. Once the counter
    // has saturated (overrun or after reset) the chain is frozen until the
    // next load; sr is all ones by then so joyD stays high either way.
    assign w_load  = ~w_ld_n;
    assign w_shift = r_ck_hist & ~w_ck & w_ld_n & (r_cnt != CNT_FULL);
    assign w_done  = w_shift & (r_cnt == 5'd15);

    always_comb begin
        w_sr_next  = r_sr;
        w_cnt_next = r_cnt;
        if (w_load) begin
            w_sr_next  = load_word(joy1, joy2);
            w_cnt_next = 5'd0;
        end else if (w_shift) begin
            w_sr_next  = {1'b1, r_sr[15:1]};
            w_cnt_next = r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ck_sync   <= '0;
            r_ld_sync   <= '1;
            r_s_sync    <= '1;
            r_ck_hist   <= 1'b0;
            r_sr        <= 16'hFFFF;
            r_cnt       <= CNT_FULL;
            r_joyD      <= 1'b1;
            r_frameDone <= 1'b0;
        end else begin
            // ---- synchronizer stage ----
            r_ck_sync   <= {r_ck_sync[SYNC-2:0], link.joyCk};
            r_ld_sync   <= {r_ld_sync[SYNC-2:0], link.joyLd};
            r_s_sync    <= {r_s_sync[SYNC-2:0], link.joyS};
            r_ck_hist   <= w_ck;
            // ---- chain / output stage ----
            r_sr        <= w_sr_next;
            r_cnt       <= w_cnt_next;
            r_joyD      <= w_sel ? w_sr_next[0] : 1'b1;
            r_frameDone <= w_done;
        end
    end

    assign link.joyD = r_joyD;
    assign frameDone = r_frameDone;

endmodule

// File: tb/tb_joystick_serializer.sv
// ---------------------------------------------------------------------------
// tb_joystick_serializer
//
// A poller driver clocks frames out of the responder. The reference model is
// a queue of expected t-bits built from a table of which joystick bit feeds
// each frame slot; every fall consumes one entry. Expected samples and
// expected frameDone cycles are queued by the driver and consumed by an
// independent monitor.
// ---------------------------------------------------------------------------
module tb_joystick_serializer;

    localparam int SYNC  = 2;
    localparam int PHASE = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       frameDone;

    joystick_serializer_if lnk ();

    joystick_serializer #(.SYNC(SYNC)) dut (
        .clock     (clock),
        .reset     (reset),
        .link      (lnk),
        .joy1      (joy1),
        .joy2      (joy2),
        .frameDone (frameDone)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---- reference model ----
    // Source of each frame slot as an index into {joy2, joy1}; -1 = marker.
    int src_tab [16] = '{-1, -1, 13, 12, 8, 9, 10, 11,
                         -1, -1,  5,  4, 0, 1,  2,  3};
    logic mq[$];         // remaining t-bits of the loaded frame
    int   model_cnt = 16;

    logic exp_q[$];      // expected joyD at each sample strobe
    int   done_q[$];     // expected cycle of each frameDone pulse
    logic smp = 1'b0;

    task automatic model_load(input logic [7:0] a1, input logic [7:0] a2);
        logic [15:0] both;
        both = {a2, a1};
        mq.delete();
        for (int t = 0; t < 16; t++)
            mq.push_back(src_tab[t] < 0 ? 1'b1 : ~both[src_tab[t]]);
        model_cnt = 0;
    endtask

    // ---- poller driver primitives (inputs change on negedge) ----
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load();
        lnk.joyLd = 1'b0;
        model_load(joy1, joy2);
        wait_neg(PHASE);
        lnk.joyLd = 1'b1;
        wait_neg(PHASE);
    endtask

    task automatic high_phase();
        lnk.joyCk = 1'b1;
        wait_neg(PHASE - 1);
        exp_q.push_back(lnk.joyS ? (mq.size() > 0 ? mq[0] : 1'b1) : 1'b1);
        smp = 1'b1;
        wait_neg(1);
        smp = 1'b0;
    endtask

    task automatic fall_phase();
        lnk.joyCk = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        if (model_cnt == 15) done_q.push_back(cyc + SYNC + 1);
        if (model_cnt < 16) model_cnt++;
        wait_neg(PHASE);
    endtask

    task automatic frame(input logic [7:0] a1, input logic [7:0] a2, input int nsh,
                         input logic [15:0] s_low, input int chg_at,
                         input logic [7:0] chg_val);
        joy1 = a1;
        joy2 = a2;
        do_load();
        for (int i = 0; i < nsh; i++) begin
            lnk.joyS = (i < 16) ? ~s_low[i] : 1'b1;
            if (i == chg_at) joy1 = chg_val;
            high_phase();
            fall_phase();
        end
        lnk.joyS = 1'b1;
    endtask

    // ---- monitor ----
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (smp) begin
                if (exp_q.size() == 0) chk("sample_without_expectation", 1, 0);
                else chk("joyD_sample", int'(lnk.joyD), int'(exp_q.pop_front()));
            end
            if (frameDone) begin
                if (done_q.size() == 0) chk("unexpected_frameDone", 1, 0);
                else chk("frameDone_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // ---- stimulus ----
    initial begin
        reset     = 1'b1;
        lnk.joyCk = 1'b0;
        lnk.joyLd = 1'b1;
        lnk.joyS  = 1'b1;
        joy1      = 8'h00;
        joy2      = 8'h00;
        wait_neg(3);
        chk("reset_joyD", int'(lnk.joyD), 1);
        chk("reset_frameDone", int'(frameDone), 0);
        reset = 1'b0;
        wait_neg(4);

        // Directed frames
        frame(8'h01, 8'h00, 16, 16'h0000, -1, 8'h00);
        frame(8'h00, 8'h3F, 18, 16'h0000, -1, 8'h00);
        frame(8'h2A, 8'h15, 16, 16'h0000, -1, 8'h00);
        frame(8'h3F, 8'h00, 16, 16'h0000, -1, 8'h00);
        frame(8'h00, 8'h3F, 16, 16'h0000, -1, 8'h00);
        frame(8'h00, 8'h00, 16, 16'h0078, -1, 8'h00);
        frame(8'h00, 8'h00, 16, 16'h0000,  5, 8'h10);
        frame(8'h10, 8'h00, 16, 16'h0000, -1, 8'h00);

        // Reset mid-frame after five shifts
        joy1 = 8'h3F;
        joy2 = 8'h3F;
        do_load();
        for (int i = 0; i < 5; i++) begin
            high_phase();
            fall_phase();
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("joyD_after_midframe_reset", int'(lnk.joyD), 1);
        @(negedge clock);
        reset = 1'b0;
        mq.delete();
        model_cnt = 16;
        for (int i = 0; i < 3; i++) begin
            high_phase();
            fall_phase();
        end

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            logic [7:0]  a1, a2, cv;
            logic [15:0] sm;
            int          ns, ca;
            a1 = 8'($urandom);
            a2 = 8'($urandom);
            cv = 8'($urandom);
            ns = $urandom_range(16, 18);
            ca = $urandom_range(0, 15);
            sm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            frame(a1, a2, ns, sm, ca, cv);
        end

        wait_neg(10);
        chk("pending_frameDone", done_q.size(), 0);
        chk("pending_samples", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/joystick_serializer.md
# joystick_serializer

Responder end of the two-wire joystick shift-register link. It emulates the 16-bit parallel-in/serial-out chain that the host-side joystick poller clocks with `joyCk`/`joyLd`. It accepts two active-high joystick states and drives the serial `joyD` line so the poller reconstructs exactly those states. It is used in the adapter/loopback designs, where one FPGA presents DB9 state to another FPGA running the poller.

## Interface
- `SYNC`, default 2: synchronizer flops on `joyCk`, `joyLd` and `joyS`; legal values 2..3.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `joyCk`  in  1  serial clock from poller; asynchronous to `clock`.
- `joyLd`  in  1  active-low parallel load from poller; asynchronous.
- `joyS`  in  1  chain select, active-high; when low the chain is idle.
- `joyD`  out  1  serial data to poller; active-low buttons, idle/marker bits high.
- `joy1`  in  8  joystick 1; bit0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2; 1 = pressed; bits 7:6 ignored.
- `joy2`  in  8  joystick 2, same layout.
- `frameDone`  out  1  one-clock pulse on the 16th shift after a load.

## Operation
- Each of `joyCk`, `joyLd` and `joyS` passes through `SYNC` flops plus one history flop for `joyCk`, used for edge detection.
- Internal state: a 16-bit register `sr`, a 5-bit shift counter `cnt` (0..16, saturating) and the registered `joyD`.
- The frame order is the serial sequence t0..t15, with t0 presented after load. Every bit is inverted (`~`):
  - t0, t1 = 1 (end markers; the poller requires both high to terminate).
  - t2 = ~joy2[5], t3 = ~joy2[4], t4 = ~joy2[0], t5 = ~joy2[1], t6 = ~joy2[2], t7 = ~joy2[3].
  - t8, t9 = 1.
  - t10 = ~joy1[5], t11 = ~joy1[4], t12 = ~joy1[0], t13 = ~joy1[1], t14 = ~joy1[2], t15 = ~joy1[3].
- Load is level-sensitive, like a real PISO part:
  - Every clock that synced `joyLd` = 0, `sr` reloads from the live `joy1`/`joy2` and `cnt` clears to 0.
  - Clock edges are ignored during load.
- Shift happens on a synced `joyCk` falling edge while synced `joyLd` = 1:
  - `sr` shifts toward t0 and fills with 1.
  - `cnt` increments, saturating at 16.
- Output: `joyD` = head of `sr` (current t-bit) when synced `joyS` = 1, else 1.
- `frameDone` pulses the clock when `cnt` goes 15→16.
- Overrun: shifts beyond 16 without a load give `joyD` = 1 and no further `frameDone`.
- Simultaneous load and falling edge: load wins and `cnt` = 0.
- `joy1`/`joy2` changes after load do not affect the frame in progress.

## Timing
- Reset values:
  - `joyD` = 1, `frameDone` = 0, `sr` = 16'hFFFF, `cnt` = 16 (no frame active).
  - Synchronizers = idle: `joyCk` 0, `joyLd` 1, `joyS` 1.
- Latency, pin edge to `joyD` update: `SYNC`+1 clocks, i.e. 3 with the default. This holds for both load (t0 visible) and `joyCk` fall (next bit).
- Data advances on the `joyCk` falling edge. The poller samples while `joyCk` is high, so `joyD` is stable throughout each high phase.
- Constraint: `joyCk` high and low phases and the `joyLd` low pulse each ≥ `SYNC`+2 clocks. Shorter pulses give undefined results.
- A reset asserted mid-frame aborts the frame: `joyD` = 1 next clock, and nothing shifts until a new load.

## Test plan
- Reset mid-frame after 5 shifts → `joyD` = 1 one clock later. Further `joyCk` falls produce `joyD` = 1 and no `frameDone` until `joyLd` pulses low.
- `joy1` = 8'h01, `joy2` = 8'h00, load then 16 clocks → t0..t15 all 1 except t12 = 0; `frameDone` one pulse, 3 clocks after the 16th fall.
- `joy1` = 8'h00, `joy2` = 8'h3F → t2..t7 = 0, all other bits 1. 17th and 18th shifts → `joyD` = 1, no second `frameDone`.
- Loopback against the poller model with ce = clock/8, for `joy1`/`joy2` = 8'h2A/8'h15, 8'h3F/8'h00, 8'h00/8'h3F → the poller outputs equal the inputs after each frame.
- `joyS` = 0 during a frame → `joyD` = 1 while low; shifting continues; `frameDone` still pulses.
- `joy1` changes from 8'h00 to 8'h10 at t5 → current frame unchanged (t11 = 1); next frame t11 = 0.
